cdnsusbhs_clkgate_ctrl: RTL and testbench

//  Idle-driven clock-gate sequencer on the free-running core clock. Counts idle cycles, requests

---
 rtl/cdnsusbhs_clkgate_ctrl_pkg.sv | 24 ++
 rtl/cdnsusbhs_clkgate_ctrl_if.sv | 31 +++
 rtl/cdnsusbhs_clkgate_tmr.sv | 37 +++
 rtl/cdnsusbhs_clkgate_ctrl.sv | 118 +++++++++++
 tb/tb_cdnsusbhs_clkgate_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdnsusbhs_clkgate_ctrl_pkg.sv
// Shared types and defaults for the idle-driven clock-gate sequencer.
package cdnsusbhs_clkgate_ctrl_pkg;

  // Default counter widths
  localparam int IDLE_W_DEF = 16;
  localparam int WAKE_W_DEF = 8;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_REQ   = 2'b01,
    ST_GATED = 2'b10,
    ST_WAKE  = 2'b11
  } cg_state_e;

  // Any of these conditions pulls the sequencer back toward a running clock.
  // It aborts a pending request and also starts the wake-up from GATED.
  function automatic logic exit_cond(input logic activity,
                                     input logic wakeup,
                                     input logic gate_en);
    return activity | wakeup | ~gate_en;
  endfunction

endpackage

// File: rtl/cdnsusbhs_clkgate_ctrl_if.sv
// Control/status bundle between the clock-gate sequencer and its surroundings.
// The master modport is the sequencer side; the slave modport is the system side.
interface cdnsusbhs_clkgate_ctrl_if
  import cdnsusbhs_clkgate_ctrl_pkg::*;
#(
  parameter int IDLE_W = IDLE_W_DEF,
  parameter int WAKE_W = WAKE_W_DEF
);

  logic              gate_en;
  logic [IDLE_W-1:0] idle_thresh;
  logic [WAKE_W-1:0] wake_dly;
  logic              activity;
  logic              wakeup;
  logic              gate_ok;
  logic              clk_en;
  logic              gate_req;
  logic              gated;
  logic              wake_pls;

  modport master (
    input  gate_en, idle_thresh, wake_dly, activity, wakeup, gate_ok,
    output clk_en, gate_req, gated, wake_pls
  );

  modport slave (
    output gate_en, idle_thresh, wake_dly, activity, wakeup, gate_ok,
    input  clk_en, gate_req, gated, wake_pls
  );

endinterface

// File: rtl/cdnsusbhs_clkgate_tmr.sv
// Generic counter used for the idle count and the wake settle delay.
// Clear beats load beats increment beats decrement. Counting saturates
// at both ends. tc flags that the count equals the supplied compare value.
module cdnsusbhs_clkgate_tmr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Count register: prioritised clear/load/inc/dec with saturation at both ends
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else if (dec) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/cdnsusbhs_clkgate_ctrl.sv
// Idle-driven clock-gate sequencer. Runs on the free-running core clock,
// counts idle cycles, negotiates a stop with the gated domain, drops clk_en,
// and restores the clock with a programmable settle delay on wake-up.
module cdnsusbhs_clkgate_ctrl
  import cdnsusbhs_clkgate_ctrl_pkg::*;
#(
  parameter int IDLE_W = IDLE_W_DEF,
  parameter int WAKE_W = WAKE_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
  cdnsusbhs_clkgate_ctrl_if.master cg
);

  cg_state_e st;

  logic exit_now;
  logic idle_match;
  logic wake_done;
  logic go_req;

  logic idle_clear;
  logic idle_inc;
  logic wake_load;
  logic wake_dec;

  assign exit_now = exit_cond(cg.activity, cg.wakeup, cg.gate_en);

  // Threshold of zero disables gating entirely, so the match is qualified here
  assign go_req = (st == ST_RUN) && idle_match && (cg.idle_thresh != '0) &&
                  cg.gate_en && !cg.activity;

  // The idle count restarts whenever we come back to RUN and on any activity in RUN
  assign idle_clear = ((st == ST_RUN)  && (cg.activity || !cg.gate_en)) ||
                      ((st == ST_REQ)  && exit_now) ||
                      ((st == ST_WAKE) && wake_done);
  assign idle_inc   = (st == ST_RUN);

  // Settle delay is captured from wake_dly at the moment the wake-up begins
  assign wake_load = (st == ST_GATED) && exit_now;
  assign wake_dec  = (st == ST_WAKE);

  cdnsusbhs_clkgate_tmr #(.W(IDLE_W)) u_idle_tmr (
    .clk      (clk),
    .rst      (rst),
    .clear    (idle_clear),
    .load     (1'b0),
    .load_val ({IDLE_W{1'b0}}),
    .inc      (idle_inc),
    .dec      (1'b0),
    .tc_val   (cg.idle_thresh),
    .tc       (idle_match)
  );

  cdnsusbhs_clkgate_tmr #(.W(WAKE_W)) u_wake_tmr (
    .clk      (clk),
    .rst      (rst),
    .clear    (1'b0),
    .load     (wake_load),
    .load_val (cg.wake_dly),
    .inc      (1'b0),
    .dec      (wake_dec),
    .tc_val   ({WAKE_W{1'b0}}),
    .tc       (wake_done)
  );

  // Sequencer state and all registered outputs; clk_en is low only while GATED
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_RUN;
      cg.clk_en   <= 1'b1;
      cg.gate_req <= 1'b0;
      cg.gated    <= 1'b0;
      cg.wake_pls <= 1'b0;
    end else begin
      cg.wake_pls <= 1'b0;
      case (st)
        ST_RUN: begin
          if (go_req) begin
            st          <= ST_REQ;
            cg.gate_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (exit_now) begin
            st          <= ST_RUN;
            cg.gate_req <= 1'b0;
          end else if (cg.gate_ok) begin
            st          <= ST_GATED;
            cg.clk_en   <= 1'b0;
            cg.gated    <= 1'b1;
          end
        end
        ST_GATED: begin
          if (exit_now) begin
            st          <= ST_WAKE;
            cg.clk_en   <= 1'b1;
            cg.gated    <= 1'b0;
            cg.wake_pls <= 1'b1;
          end
        end
        ST_WAKE: begin
          if (wake_done) begin
            st          <= ST_RUN;
            cg.gate_req <= 1'b0;
          end
        end
        default: begin
          st          <= ST_RUN;
          cg.clk_en   <= 1'b1;
          cg.gate_req <= 1'b0;
          cg.gated    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdnsusbhs_clkgate_ctrl.sv
// Bench for the clock-gate sequencer: directed vector table, multi-cycle
// corner sequences, and a randomized run against a behavioural model.
module tb_cdnsusbhs_clkgate_ctrl;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  cdnsusbhs_clkgate_ctrl_if #(.IDLE_W(16), .WAKE_W(8)) cg ();

  cdnsusbhs_clkgate_ctrl #(.IDLE_W(16), .WAKE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .cg  (cg.master)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gate_en;
    logic        activity;
    logic        wakeup;
    logic        gate_ok;
    logic [15:0] thresh;
    logic [7:0]  dly;
    logic        e_clk_en;
    logic        e_gate_req;
    logic        e_gated;
    logic        e_pls;
    logic [15:0] e_idle;
  } vec_t;

  vec_t vecs[16];

  // Behavioural model state
  int  m_idle;
  int  m_rem;
  bit  m_req;
  bit  m_stop;
  bit  m_wake;
  bit  m_pls;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic ge, input logic [15:0] th,
                                input logic [7:0] wd, input logic act, input logic wk,
                                input logic ok);
    rst            = r;
    cg.gate_en     = ge;
    cg.idle_thresh = th;
    cg.wake_dly    = wd;
    cg.activity    = act;
    cg.wakeup      = wk;
    cg.gate_ok     = ok;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic go_gated();
    int k;
    apply_stimulus(1'b1, 1'b1, 16'd2, 8'd0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    k = 0;
    while (!cg.gated && k < 10) begin
      tick();
      k++;
    end
    check_output("reach_gated", 32'(cg.gated), 32'd1);
  endtask

  // Spec-level model: one step per clock using the sampled inputs
  task automatic model_step(input logic r, input logic ge, input logic [15:0] th,
                            input logic [7:0] wd, input logic act, input logic wk,
                            input logic ok);
    bit leave;
    bit go;
    if (r) begin
      m_idle = 0; m_rem = 0; m_req = 0; m_stop = 0; m_wake = 0; m_pls = 0;
    end else begin
      leave = act || wk || !ge;
      m_pls = 0;
      if (m_stop) begin
        if (leave) begin
          m_stop = 0; m_wake = 1; m_rem = int'(wd); m_pls = 1;
        end
      end else if (m_wake) begin
        if (m_rem == 0) begin
          m_wake = 0; m_req = 0; m_idle = 0;
        end else begin
          m_rem = m_rem - 1;
        end
      end else if (m_req) begin
        if (leave) begin
          m_req = 0; m_idle = 0;
        end else if (ok) begin
          m_stop = 1;
        end
      end else begin
        go = (th != 0) && (m_idle == int'(th)) && ge && !act;
        if (act || !ge) m_idle = 0;
        else if (m_idle < 65535) m_idle = m_idle + 1;
        if (go) m_req = 1;
      end
    end
  endtask

  initial begin
    int  viol;
    bit  seen_req;
    logic [15:0] rth;
    logic r, ge, act, wk, ok;
    logic [7:0] wd;

    apply_stimulus(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // ---------------- vector table: thresh=2, wake_dly=1 ----------------
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd1};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd2};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b1,1'b0,1'b0,16'd3};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd1};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd2};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b1,1'b0,1'b0,16'd3};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b1,1'b0,1'b0,16'd3};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,16'd2,8'd1, 1'b0,1'b1,1'b1,1'b0,16'd3};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b0,1'b1,1'b1,1'b0,16'd3};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0,16'd2,8'd1, 1'b1,1'b1,1'b0,1'b1,16'd3};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b1,1'b0,16'd2,8'd1, 1'b1,1'b1,1'b0,1'b0,16'd3};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd0};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b1,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd1};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b0,1'b0,16'd2,8'd1, 1'b1,1'b0,1'b0,1'b0,16'd0};

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].gate_en, vecs[i].thresh, vecs[i].dly,
                     vecs[i].activity, vecs[i].wakeup, vecs[i].gate_ok);
      tick();
      check_output($sformatf("vec%0d_clk_en", i),   32'(cg.clk_en),   32'(vecs[i].e_clk_en));
      check_output($sformatf("vec%0d_gate_req", i), 32'(cg.gate_req), 32'(vecs[i].e_gate_req));
      check_output($sformatf("vec%0d_gated", i),    32'(cg.gated),    32'(vecs[i].e_gated));
      check_output($sformatf("vec%0d_wake_pls", i), 32'(cg.wake_pls), 32'(vecs[i].e_pls));
      check_output($sformatf("vec%0d_idle", i),     32'(dut.u_idle_tmr.cnt), 32'(vecs[i].e_idle));
    end

    // ---------------- gate request timing with thresh=8 ----------------
    apply_stimulus(1'b1, 1'b1, 16'd8, 8'd0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_output($sformatf("t1_gate_req_c%0d", k), 32'(cg.gate_req), 32'(k == 9));
    end
    tick();
    check_output("t1_clk_en_low", 32'(cg.clk_en), 32'd0);
    check_output("t1_gated",      32'(cg.gated),  32'd1);

    // ---------------- wake-up with settle delay 3 ----------------
    cg.wake_dly = 8'd3;
    cg.wakeup   = 1'b1;
    tick();
    cg.wakeup   = 1'b0;
    check_output("t3_wake_pls", 32'(cg.wake_pls), 32'd1);
    check_output("t3_clk_en",   32'(cg.clk_en),   32'd1);
    check_output("t3_gated",    32'(cg.gated),    32'd0);
    check_output("t3_gate_req", 32'(cg.gate_req), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_output($sformatf("t3_hold_req_%0d", k), 32'(cg.gate_req), 32'd1);
      check_output($sformatf("t3_pls_low_%0d", k),  32'(cg.wake_pls), 32'd0);
    end
    tick();
    check_output("t3_req_drop", 32'(cg.gate_req), 32'd0);

    // ---------------- gate_en dropped while gated ----------------
    go_gated();
    cg.gate_en  = 1'b0;
    cg.wake_dly = 8'd0;
    tick();
    check_output("t5_wake_pls", 32'(cg.wake_pls), 32'd1);
    check_output("t5_clk_en",   32'(cg.clk_en),   32'd1);
    tick();
    check_output("t5_req_drop", 32'(cg.gate_req), 32'd0);
    check_output("t5_pls_once", 32'(cg.wake_pls), 32'd0);
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cg.gate_req !== 1'b0) viol++;
    end
    check_output("t5_no_rereq", 32'(viol), 32'd0);

    // ---------------- reset in GATED and in WAKE ----------------
    go_gated();
    rst = 1'b1;
    tick();
    check_output("t6g_clk_en",   32'(cg.clk_en),   32'd1);
    check_output("t6g_gate_req", 32'(cg.gate_req), 32'd0);
    check_output("t6g_gated",    32'(cg.gated),    32'd0);
    check_output("t6g_wake_pls", 32'(cg.wake_pls), 32'd0);
    go_gated();
    cg.wake_dly = 8'd5;
    cg.wakeup   = 1'b1;
    tick();
    cg.wakeup   = 1'b0;
    check_output("t6w_in_wake", 32'(cg.wake_pls), 32'd1);
    rst = 1'b1;
    tick();
    check_output("t6w_clk_en",   32'(cg.clk_en),   32'd1);
    check_output("t6w_gate_req", 32'(cg.gate_req), 32'd0);
    check_output("t6w_gated",    32'(cg.gated),    32'd0);
    check_output("t6w_wake_pls", 32'(cg.wake_pls), 32'd0);
    check_output("t6w_idle",     32'(dut.u_idle_tmr.cnt), 32'd0);

    // ---------------- thresh=0: never gate, idle count saturates ----------------
    apply_stimulus(1'b1, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    seen_req = 1'b0;
    for (int k = 1; k <= 65600; k++) begin
      tick();
      if (cg.gate_req) seen_req = 1'b1;
      if (k == 10000) check_output("t4_idle_10000", 32'(dut.u_idle_tmr.cnt), 32'd10000);
    end
    check_output("t4_never_req", 32'(seen_req), 32'd0);
    check_output("t4_idle_sat",  32'(dut.u_idle_tmr.cnt), 32'h0000FFFF);

    // ---------------- randomized run against the model ----------------
    rth = 16'd3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rth = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 5));
      r   = (c == 0) || ($urandom % 100 == 0);
      ge  = ($urandom % 16) != 0;
      act = ($urandom % 6) == 0;
      wk  = ($urandom % 10) == 0;
      ok  = ($urandom % 2) == 0;
      wd  = 8'($urandom % 4);
      apply_stimulus(r, ge, rth, wd, act, wk, ok);
      model_step(r, ge, rth, wd, act, wk, ok);
      tick();
      check_output("rnd_clk_en",   32'(cg.clk_en),   32'(!m_stop));
      check_output("rnd_gate_req", 32'(cg.gate_req), 32'(m_req));
      check_output("rnd_gated",    32'(cg.gated),    32'(m_stop));
      check_output("rnd_wake_pls", 32'(cg.wake_pls), 32'(m_pls));
      check_output("rnd_idle",     32'(dut.u_idle_tmr.cnt), 32'(m_idle));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
